// File: rtl/prog_pattern_detector.sv
// Runtime-programmable serial pattern detector (MSB first, overlap selectable).
// Define PROG_PATTERN_CNT_EN to build the saturating match counter and cnt_clr.
module prog_pattern_detector #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] DEF_PAT = 5'b11010,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stream_valid,
    input  logic                       stream_in,
    input  logic                       pat_load,
    input  logic [PAT_W-1:0]           pat_value,
    input  logic [$clog2(PAT_W+1)-1:0] pat_len,
    input  logic                       overlap_en,
    input  logic                       cnt_clr,
    output logic                       pattern_found,
    output logic [CNT_W-1:0]           match_count
);
    localparam int            LW   = $clog2(PAT_W+1);
    localparam logic [LW-1:0] FULL = LW'(PAT_W);

    typedef enum logic {FILLING, SEARCH} state_t;

    state_t           state, state_next;
    logic [PAT_W-1:0] history, history_next, pattern, mask;
    logic [LW-1:0]    fill, fill_next, fill_inc, len, len_eff;
    logic             sample, match;

    always_comb begin
        sample       = stream_valid & ~pat_load;
        history_next = {history[PAT_W-2:0], stream_in};
        fill_inc     = (fill == FULL) ? FULL : fill + 1'b1;
        // Shifting by len == PAT_W clears everything, giving an all-ones mask.
        mask         = ~({PAT_W{1'b1}} << len);
        match        = sample && (fill_inc >= len)
                       && ((history_next & mask) == (pattern & mask));
        len_eff      = (pat_len == '0 || pat_len > FULL) ? FULL : pat_len;
    end

    // State tracks whether enough fresh bits are held to compare (fill >= len).
    always_comb begin
        state_next = state;
        fill_next  = fill;
        if (pat_load) begin
            fill_next  = '0;
            state_next = FILLING;
        end else if (sample) begin
            if (match && !overlap_en) begin
                fill_next  = '0;
                state_next = FILLING;
            end else begin
                fill_next  = fill_inc;
                state_next = (fill_inc >= len) ? SEARCH : FILLING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FILLING;
            history       <= '0;
            fill          <= '0;
            pattern       <= DEF_PAT;
            len           <= FULL;
            pattern_found <= 1'b0;
        end else begin
            state         <= state_next;
            fill          <= fill_next;
            pattern_found <= match;
            if (pat_load) begin
                history <= '0;
                pattern <= pat_value;
                len     <= len_eff;
            end else if (sample) begin
                history <= history_next;
            end
        end
    end

`ifdef PROG_PATTERN_CNT_EN
    logic [CNT_W-1:0] cnt;

    // A clear coinciding with a match leaves that match counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (match)
            cnt <= cnt_clr ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
        else if (cnt_clr)
            cnt <= '0;
    end

    assign match_count = cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
